id_ex_stage: RTL

ID/EX pipeline register plus EX-side operand preparation; feeds the ALU's A, B and 4-bit control inputs directly.
Captures decoded instruction fields each cycle, honouring stall, flush and load-use bubbles.
Resolves EX/MEM and MEM/WB data forwarding, decodes the ALU control code, and computes the branch target.
Raises the load-use stall request for the front end.

---
 rtl/id_ex_if.sv | 55 +++++
 rtl/id_ex_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID fields, pipeline control, forward sources and EX-side outputs.
// The master drives the ID side and the forward sources; the slave is the stage itself.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [1:0]      id_alu_op;
  logic [3:0]      id_funct;
  logic            id_alu_src;
  logic [4:0]      id_ctrl;
  logic            stall;
  logic            flush;
  logic            exmem_reg_write;
  logic [RA_W-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_alu_result;
  logic            memwb_reg_write;
  logic [RA_W-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_wb_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic [4:0]      ex_ctrl;
  logic [XLEN-1:0] ex_branch_target;
  logic            load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct, id_alu_src, id_ctrl, stall, flush,
           exmem_reg_write, exmem_rd, exmem_alu_result,
           memwb_reg_write, memwb_rd, memwb_wb_data,
    input  ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_ctrl,
           ex_branch_target, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct, id_alu_src, id_ctrl, stall, flush,
           exmem_reg_write, exmem_rd, exmem_alu_result,
           memwb_reg_write, memwb_rd, memwb_wb_data,
    output ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_ctrl,
           ex_branch_target, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding, registered ALU control decode,
// branch target adder and load-use hazard detection.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [4:0]      ctrl;
  } ex_reg_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  ex_reg_t q, cap;
  logic    luse;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // funct = {funct7[5], funct3}; funct7[5] only means SUB on register-register forms
  function automatic logic [3:0] alu_dec(input logic [1:0] op, input logic [3:0] funct,
                                         input logic src);
    logic [3:0] r;
    r = ALU_NOP;
    case (op)
      2'b00: r = ALU_ADD;
      2'b01: r = ALU_SUB;
      2'b10: begin
        case (funct[2:0])
          3'b000:  r = (funct[3] && !src) ? ALU_SUB : ALU_ADD;
          3'b111:  r = ALU_AND;
          3'b110:  r = ALU_OR;
          default: r = ALU_NOP;
        endcase
      end
      default: r = ALU_NOP;
    endcase
    return r;
  endfunction

  // x0 never forwards, so its registered read data (0) passes through
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] r;
    r = rf;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs)
      r = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs)
      r = bus.memwb_wb_data;
    return r;
  endfunction

  always_comb begin
    cap = '0;
    if (bus.id_valid) begin
      cap.valid    = 1'b1;
      cap.pc       = bus.id_pc;
      cap.rs1_data = bus.id_rs1_data;
      cap.rs2_data = bus.id_rs2_data;
      cap.imm      = bus.id_imm;
      cap.rs1      = bus.id_rs1;
      cap.rs2      = bus.id_rs2;
      cap.rd       = bus.id_rd;
      cap.alu_ctrl = alu_dec(bus.id_alu_op, bus.id_funct, bus.id_alu_src);
      cap.alu_src  = bus.id_alu_src;
      cap.ctrl     = bus.id_ctrl;
    end
  end

  // ctrl[4] is mem_read
  assign luse = q.valid && q.ctrl[4] && (q.rd != '0) && bus.id_valid &&
                ((q.rd == bus.id_rs1) || (q.rd == bus.id_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              q <= '0;
    else if (bus.flush)      q <= '0;
    else if (luse)           q <= '0;
    else if (!bus.stall)     q <= cap;
  end

  assign fwd_a = fwd(q.rs1, q.rs1_data);
  assign fwd_b = fwd(q.rs2, q.rs2_data);

  assign bus.ex_valid         = q.valid;
  assign bus.ex_pc            = q.pc;
  assign bus.alu_a            = fwd_a;
  assign bus.alu_b            = q.alu_src ? q.imm : fwd_b;
  assign bus.alu_ctrl         = q.alu_ctrl;
  assign bus.ex_store_data    = fwd_b;
  assign bus.ex_rd            = q.rd;
  assign bus.ex_ctrl          = q.ctrl;
  assign bus.ex_branch_target = q.pc + q.imm;
  assign bus.load_use_stall   = luse;
endmodule
